row_slider: RTL and testbench

ROW_SLIDER -- requirements
Module: row_slider

---
 rtl/row_slider.sv | 153 +++++++++++++++
 tb/tb_row_slider.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/row_slider.sv
// ============================================================================
// row_slider: moving block row that bounces across a COLS-wide grid, freezes
// on a drop edge and resolves against the row beneath.
// Optional feature macro: ROW_SLIDER_WRAP_EN (rotate circularly instead of bounce)
// Revision: 1.0
// ============================================================================
`default_nettype none

module row_slider #(
  parameter int COLS        = 16,
  parameter int BASE_PERIOD = 3200000,
  parameter int PERIOD_DEC  = 200000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [3:0]      level,
  input  logic [3:0]      width,
  input  logic            start,
  input  logic            drop,
  input  logic [COLS-1:0] below_mask,
  output logic [COLS-1:0] row_mask,
  output logic [COLS-1:0] result_mask,
  output logic            busy,
  output logic            next_signal,
  output logic            fail
);

  localparam int CW = $clog2(BASE_PERIOD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_tick;
  logic [CW-1:0]   r_period;
  logic            r_dir;
  logic            r_drop_q;

  logic            w_drop_rise;
  logic            w_wrap;
  logic            w_load;
  logic            w_step;
  logic            w_resolve;
  logic [3:0]      w_lvl;
  logic [3:0]      w_wid;
  logic [CW-1:0]   w_period;
  logic [COLS-1:0] w_init;
  logic [COLS-1:0] w_overlap;

  assign w_drop_rise = drop & ~r_drop_q;
  assign w_wrap      = (r_tick == r_period - CW'(1));
  assign w_overlap   = row_mask & below_mask;
  assign busy        = (r_state != IDLE);

  always_comb begin
    w_lvl    = (level == 4'd0) ? 4'd1 : level;
    w_wid    = (width == 4'd0) ? 4'd1 : width;
    w_period = CW'(BASE_PERIOD - int'(w_lvl) * PERIOD_DEC);
    w_init   = '0;
    for (int i = 0; i < COLS; i++) begin
      if (i < int'(w_wid)) w_init[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_resolve   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = MOVE;
        end
      end
      MOVE: begin
        // A drop edge takes priority over a coincident step.
        if (w_drop_rise)  w_state_nxt = RESOLVE;
        else if (w_wrap)  w_step      = 1'b1;
      end
      RESOLVE: begin
        w_resolve   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_mask    <= '0;
      result_mask <= '0;
      r_tick      <= '0;
      r_period    <= '0;
      r_dir       <= 1'b1;
      r_drop_q    <= 1'b0;
      next_signal <= 1'b0;
      fail        <= 1'b0;
    end else begin
      r_drop_q    <= drop;
      next_signal <= 1'b0;
      fail        <= 1'b0;
      if (w_load) begin
        row_mask <= w_init;
        r_dir    <= 1'b1;
        r_tick   <= '0;
        r_period <= w_period;
      end else if (r_state == MOVE && !w_drop_rise) begin
        r_tick <= w_wrap ? '0 : r_tick + CW'(1);
        if (w_step && !(&row_mask)) begin
`ifdef ROW_SLIDER_WRAP_EN
          row_mask <= {row_mask[COLS-2:0], row_mask[COLS-1]};
`else
          if (r_dir) begin
            if (row_mask[COLS-1]) begin
              r_dir    <= 1'b0;
              row_mask <= row_mask >> 1;
            end else begin
              row_mask <= row_mask << 1;
            end
          end else begin
            if (row_mask[0]) begin
              r_dir    <= 1'b1;
              row_mask <= row_mask << 1;
            end else begin
              row_mask <= row_mask >> 1;
            end
          end
`endif
        end
      end
      if (w_resolve) begin
        row_mask    <= w_overlap;
        result_mask <= w_overlap;
        if (|w_overlap) next_signal <= 1'b1;
        else            fail        <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_row_slider.sv
// ============================================================================
// tb_row_slider: directed self-checking bench for row_slider (COLS=16,
// BASE_PERIOD=32, PERIOD_DEC=2). Revision: 1.0
// ============================================================================
`default_nettype none

module tb_row_slider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  level = 4'd1;
  logic [3:0]  width = 4'd3;
  logic        start = 1'b0;
  logic        drop = 1'b0;
  logic [15:0] below_mask = 16'hFFFF;
  logic [15:0] row_mask;
  logic [15:0] result_mask;
  logic        busy;
  logic        next_signal;
  logic        fail;

  int total = 0;
  int bad   = 0;

`ifdef ROW_SLIDER_WRAP_EN
  localparam logic [15:0] C_AFTER_TOP = 16'hC001;
`else
  localparam logic [15:0] C_AFTER_TOP = 16'h7000;
`endif

  row_slider #(.COLS(16), .BASE_PERIOD(32), .PERIOD_DEC(2)) dut (
    .clk(clk), .resetn(resetn), .level(level), .width(width),
    .start(start), .drop(drop), .below_mask(below_mask),
    .row_mask(row_mask), .result_mask(result_mask), .busy(busy),
    .next_signal(next_signal), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    cyc(2);
    check("rst_row",    32'(row_mask),    32'h0);
    check("rst_result", 32'(result_mask), 32'h0);
    check("rst_busy",   32'(busy),        32'h0);
    check("rst_next",   32'(next_signal), 32'h0);
    check("rst_fail",   32'(fail),        32'h0);
    resetn = 1'b1;

    // Load and first step at level 1 (P=30)
    level = 4'd1; width = 4'd3; start = 1'b1;
    cyc(1); start = 1'b0;
    check("load_row",  32'(row_mask), 32'h0007);
    check("load_busy", 32'(busy),     32'h1);
    cyc(29);
    check("pre_step",  32'(row_mask), 32'h0007);
    cyc(1);
    check("step1",     32'(row_mask), 32'h000E);

    // Drop with overlap -> next_signal
    below_mask = 16'h000F; drop = 1'b1;
    cyc(1);
    check("res_busy",  32'(busy),        32'h1);
    check("res_row",   32'(row_mask),    32'h000E);
    check("res_next0", 32'(next_signal), 32'h0);
    cyc(1);
    check("hit_next",   32'(next_signal), 32'h1);
    check("hit_fail",   32'(fail),        32'h0);
    check("hit_result", 32'(result_mask), 32'h000E);
    check("hit_busy",   32'(busy),        32'h0);
    drop = 1'b0;
    cyc(1);
    check("hit_next_off", 32'(next_signal), 32'h0);
    check("idle_hold",    32'(result_mask), 32'h000E);

    // Drop with no overlap -> fail
    start = 1'b1;
    cyc(1); start = 1'b0;
    check("load2_row", 32'(row_mask), 32'h0007);
    below_mask = 16'hF000; drop = 1'b1;
    cyc(2);
    check("miss_fail",   32'(fail),        32'h1);
    check("miss_next",   32'(next_signal), 32'h0);
    check("miss_result", 32'(result_mask), 32'h0000);
    check("miss_row",    32'(row_mask),    32'h0000);
    drop = 1'b0;
    cyc(1);
    check("miss_fail_off", 32'(fail), 32'h0);

    // Level 15 -> P=2; level change mid-move has no effect
    level = 4'd15; width = 4'd3; start = 1'b1; below_mask = 16'hFFFF;
    cyc(1); start = 1'b0;
    cyc(2);
    check("fast_s1", 32'(row_mask), 32'h000E);
    cyc(2);
    check("fast_s2", 32'(row_mask), 32'h001C);
    level = 4'd1;
    cyc(2);
    check("lvl_ignored", 32'(row_mask), 32'h0038);
    cyc(20);
    check("top", 32'(row_mask), 32'hE000);
    cyc(2);
    check("after_top", 32'(row_mask), 32'(C_AFTER_TOP));

    // Drop on a step cycle: no shift
    cyc(1);
    drop = 1'b1;
    cyc(1);
    check("coinc_row",  32'(row_mask), 32'(C_AFTER_TOP));
    check("coinc_busy", 32'(busy),     32'h1);
    cyc(1);
    check("coinc_next", 32'(next_signal), 32'h1);
    check("coinc_res",  32'(result_mask), 32'(C_AFTER_TOP));

    // Width 0 -> single block; held drop must not retrigger
    level = 4'd15; width = 4'd0; start = 1'b1;
    cyc(1); start = 1'b0;
    check("w0_row", 32'(row_mask), 32'h0001);
    cyc(2);
    check("held_row", 32'(row_mask), 32'h0002);
    cyc(4);
    check("held_row2", 32'(row_mask), 32'h0008);
    check("held_busy", 32'(busy),     32'h1);
    drop = 1'b0;
    cyc(1);
    drop = 1'b1;
    cyc(1);
    check("redrop_row", 32'(row_mask), 32'h0008);
    cyc(1);
    check("redrop_next", 32'(next_signal), 32'h1);
    check("redrop_res",  32'(result_mask), 32'h0008);
    drop = 1'b0;

    // start ignored outside IDLE; reset aborts MOVE silently
    level = 4'd1; width = 4'd2; start = 1'b1;
    cyc(1); start = 1'b0;
    check("load3_row", 32'(row_mask), 32'h0003);
    width = 4'd5; start = 1'b1;
    cyc(1); start = 1'b0;
    check("start_ignored", 32'(row_mask), 32'h0003);
    cyc(3);
    drop = 1'b1;
    resetn = 1'b0;
    cyc(1);
    check("abort_busy",   32'(busy),        32'h0);
    check("abort_row",    32'(row_mask),    32'h0000);
    check("abort_result", 32'(result_mask), 32'h0000);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("abort_pulse", 32'({next_signal, fail}), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
